// File: rtl/spi_master.sv
// SPI mode-0 master. Sends one byte per accepted start and can hold SSEL low across a burst.
// It also enforces a minimum SSEL-high gap between messages.
module spi_master #(
  parameter int DIV = 4,
  parameter int GAP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       keep,
  input  logic [7:0] tx_data,
  output logic       ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       SCK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SSEL
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEAD  = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_BURST = 3'd5;
  localparam logic [2:0] S_GAPW  = 3'd6;

  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);
  localparam logic [7:0] GAP_M1 = 8'(GAP - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       ssel_q, ssel_d;
  logic       ready_q, ready_d;
  logic       rxv_q, rxv_d;
  logic [7:0] rxd_q, rxd_d;
  logic       half_done_s;

  assign half_done_s = (cnt_q == DIV_M1);

  // Next-state and output-register computation for the transfer sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    ssel_d  = ssel_q;
    ready_d = ready_q;
    rxv_d   = 1'b0;
    rxd_d   = rxd_q;
    case (state_q)
      S_IDLE, S_BURST: begin
        if (start && ready_q) begin
          sh_d    = tx_data;
          mosi_d  = tx_data[7];
          ssel_d  = 1'b0;
          bit_d   = 3'd0;
          cnt_d   = 8'd0;
          ready_d = 1'b0;
          state_d = S_LEAD;
        end else if ((state_q == S_BURST) && !keep) begin
          ssel_d  = 1'b1;
          ready_d = 1'b0;
          cnt_d   = 8'd0;
          state_d = S_GAPW;
        end else begin
          ready_d = 1'b1;
        end
      end
      S_LEAD, S_LOW: begin
        if (half_done_s) begin
          sck_d   = 1'b1;
          sh_d    = {sh_q[6:0], MISO};
          cnt_d   = 8'd0;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HIGH: begin
        if (half_done_s) begin
          sck_d = 1'b0;
          cnt_d = 8'd0;
          // The shift register's MSB already holds the next outgoing bit after the rising-edge shift
          if (bit_q != 3'd7) begin
            mosi_d  = sh_q[7];
            bit_d   = bit_q + 3'd1;
            state_d = S_LOW;
          end else begin
            rxv_d   = 1'b1;
            rxd_d   = sh_q;
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        cnt_d = 8'd0;
        if (keep) begin
          ready_d = 1'b1;
          state_d = S_BURST;
        end else begin
          ssel_d  = 1'b1;
          state_d = S_GAPW;
        end
      end
      S_GAPW: begin
        if (cnt_q == GAP_M1) begin
          cnt_d   = 8'd0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        sck_d   = 1'b0;
        ssel_d  = 1'b1;
        ready_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      ssel_q  <= 1'b1;
      ready_q <= 1'b0;
      rxv_q   <= 1'b0;
      rxd_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      ssel_q  <= ssel_d;
      ready_q <= ready_d;
      rxv_q   <= rxv_d;
      rxd_q   <= rxd_d;
    end
  end

  assign ready    = ready_q;
  assign rx_data  = rxd_q;
  assign rx_valid = rxv_q;
  assign SCK      = sck_q;
  assign MOSI     = mosi_q;
  assign SSEL     = ssel_q;

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL provide parameter DIV, default 4, meaning SCK half-period in clk cycles; legal range 4..255.
REQ-002 SHALL provide parameter GAP, default 4, meaning minimum clk cycles SSEL stays high between messages; legal range 1..255.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to send tx_data; accepted only in a cycle where ready=1.
REQ-006 SHALL have port keep  input  1  sampled at end of byte; 1 = hold SSEL low for a following byte.
REQ-007 SHALL have port tx_data  input  8  byte to transmit, MSB first.
REQ-008 SHALL have port ready  output  1  high when start is accepted.
REQ-009 SHALL have port rx_data  output  8  last byte received on MISO.
REQ-010 SHALL have port rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-011 SHALL have port SCK  output  1  SPI clock, idle low (mode 0).
REQ-012 SHALL have port MOSI  output  1  serial data out.
REQ-013 SHALL have port MISO  input  1  serial data in.
REQ-014 SHALL have port SSEL  output  1  active-low slave select.

Function
REQ-015 SHALL implement states IDLE, LEAD, HIGH, LOW, DONE, BURST, GAPW; all outputs registered.
REQ-016 SHALL, in IDLE: SSEL=1, SCK=0, ready=1; start=1 latches tx_data into shift register, sets SSEL=0, MOSI=tx_data[7], bit counter=0, next LEAD.
REQ-017 SHALL hold LEAD for DIV cycles, then drive SCK=1, sample MISO into shift register LSB, next HIGH.
REQ-018 SHALL hold HIGH for DIV cycles, then drive SCK=0; if bit counter<7, shift MOSI to next bit, increment counter, next LOW; else next DONE.
REQ-019 SHALL hold LOW for DIV cycles, then drive SCK=1, sample MISO, next HIGH.
REQ-020 SHALL produce exactly 8 SCK rising edges per byte; MOSI changes only on SCK falling edge or when entering LEAD.
REQ-021 SHALL register rx_valid=1 with rx_data=received byte at the 16*DIV-th clk edge after the accepting edge, for one cycle (DONE).
REQ-022 SHALL, from DONE, go to BURST if keep=1, else GAPW.
REQ-023 SHALL, in BURST: SSEL=0, SCK=0, ready=1; start=1 behaves as in IDLE but SSEL stays low; keep=0 with start=0 sends to GAPW.
REQ-024 SHALL, in GAPW: SSEL=1, ready=0 for GAP cycles, then IDLE.
REQ-025 SHALL ignore start when ready=0; no latch, no state change.
REQ-026 SHALL treat tx_data changes after acceptance as no effect on the byte in flight.
REQ-027 SHALL hold rx_data stable between rx_valid pulses.
REQ-028 SHALL use an 8-bit half-period counter reloaded at every state transition; no wrap beyond DIV-1.

Reset
REQ-029 SHALL, on rst=1 at any time including mid-byte, immediately force IDLE, SSEL=1, SCK=0, MOSI=0, ready=0 while rst high, rx_valid=0, rx_data=0x00, counters=0.
REQ-030 SHALL assert ready=1 in the first cycle after rst deasserts.
REQ-031 SHALL emit no partial rx_valid for a byte aborted by reset.

Verification
REQ-032 SHALL cover loopback MOSI->MISO, DIV=4, tx 0xA5, keep=0 -> rx_data=0xA5, rx_valid at edge 64 after accept, 8 SCK rises, SSEL high GAP cycles after.
REQ-033 SHALL cover MISO driven by model with 0x3C, tx 0x00 -> rx_data=0x3C; MOSI stays 0.
REQ-034 SHALL cover burst keep=1, tx 0x12 then 0x34, then keep=0 -> SSEL never rises between bytes; two rx_valid pulses; 16 SCK rises.
REQ-035 SHALL cover start pulsed during HIGH/LOW/GAPW -> ignored; exactly one byte transferred.
REQ-036 SHALL cover rst asserted after 3rd SCK rise -> SSEL=1, SCK=0 same cycle; no rx_valid; next start transfers a full byte correctly.
